// File: rtl/hash_serializer.sv
// hash_serializer: double-buffered SHA-256 digest to 32-bit word stream serializer
module hash_serializer #(
  parameter int WORD_ORDER = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] hash_data,
  input  logic         output_valid,
  output logic [31:0]  out_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [2:0]   word_index,
  output logic         busy,
  output logic         overflow,
  input  logic         clear_overflow
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [255:0] active, pending;
  logic active_valid, pending_valid, prev_ov;
  logic rise, xfer, fin, drop;
  always_comb begin
    rise = output_valid & ~prev_ov;
    out_valid = state == SEND;
    xfer = out_valid & out_ready;
    fin = xfer & (word_index == 3'd7);
    drop = rise & active_valid & pending_valid & ~fin;
    state_nx = state == IDLE ? (rise ? SEND : IDLE)
             : (fin & ~pending_valid & ~rise ? IDLE : SEND);
    out_word = !out_valid ? 32'd0
             : WORD_ORDER != 0 ? active[32*word_index +: 32]
             : active[255-32*word_index -: 32];
    out_last = out_valid & (word_index == 3'd7);
    busy = active_valid | pending_valid;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      active <= '0;
      pending <= '0;
      active_valid <= 1'b0;
      pending_valid <= 1'b0;
      prev_ov <= 1'b0;
      word_index <= 3'd0;
      overflow <= 1'b0;
    end else begin
      prev_ov <= output_valid;
      overflow <= drop | (overflow & ~clear_overflow);
      if (xfer) word_index <= word_index + 3'd1;
      if (state == IDLE) begin
        if (rise) begin
          active <= hash_data;
          active_valid <= 1'b1;
          word_index <= 3'd0;
        end
      end else if (fin) begin
        if (pending_valid) begin
          active <= pending;
          if (rise) pending <= hash_data;
          pending_valid <= rise;
        end else if (rise) active <= hash_data;
        else active_valid <= 1'b0;
      end else if (rise && !pending_valid) begin
        pending <= hash_data;
        pending_valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_hash_serializer.sv
// tb_hash_serializer: directed and table-driven checks of hash_serializer in both word orders
module tb_hash_serializer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [255:0] hash_data = '0;
  logic output_valid = 1'b0;
  logic out_ready = 1'b1;
  logic clear_overflow = 1'b0;
  logic [31:0] word0, word1;
  logic valid0, valid1, last0, last1, busy0, busy1, ovf0, ovf1;
  logic [2:0] idx0, idx1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  hash_serializer #(.WORD_ORDER(0)) dut0 (
    .clk(clk), .rst(rst), .hash_data(hash_data), .output_valid(output_valid),
    .out_word(word0), .out_valid(valid0), .out_ready(out_ready), .out_last(last0),
    .word_index(idx0), .busy(busy0), .overflow(ovf0), .clear_overflow(clear_overflow));
  hash_serializer #(.WORD_ORDER(1)) dut1 (
    .clk(clk), .rst(rst), .hash_data(hash_data), .output_valid(output_valid),
    .out_word(word1), .out_valid(valid1), .out_ready(out_ready), .out_last(last1),
    .word_index(idx1), .busy(busy1), .overflow(ovf1), .clear_overflow(clear_overflow));
  typedef logic [31:0] words_t [8];
  typedef struct {
    logic rdy;
    int   idx;
  } vec_t;
  words_t abc_w = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  words_t d2_w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                   32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
  words_t d3_w = '{32'hdeadbeef, 32'hcafef00d, 32'h0badc0de, 32'hfeedface,
                   32'h01234567, 32'h89abcdef, 32'h13579bdf, 32'h2468ace0};
  vec_t vecs [22];
  function automatic logic [255:0] pack(input words_t w);
    return {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7]};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic start(input words_t w);
    hash_data = pack(w);
    output_valid = 1'b1;
    step();
    output_valid = 1'b0;
  endtask
  initial begin
    int xfers;
    words_t exp16 [2];
    vecs[0] = '{1'b1, 0};
    for (int j = 1; j < 8; j++) begin
      vecs[3*j-2] = '{1'b0, j};
      vecs[3*j-1] = '{1'b0, j};
      vecs[3*j]   = '{1'b1, j};
    end
    step();
    step();
    check("reset_valid", {31'd0, valid0}, 32'd0);
    check("reset_word", word0, 32'd0);
    check("reset_busy", {31'd0, busy0}, 32'd0);
    check("reset_ovf", {31'd0, ovf0}, 32'd0);
    rst = 1'b1;
    step();
    // abc digest, both word orders, consumer always ready
    start(abc_w);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("abc_o0_w%0d", i), word0, abc_w[i]);
      check($sformatf("abc_o1_w%0d", i), word1, abc_w[7-i]);
      check($sformatf("abc_idx%0d", i), {29'd0, idx0}, i);
      check($sformatf("abc_last%0d", i), {31'd0, last0}, {31'd0, i == 7});
      check($sformatf("abc_valid%0d", i), {31'd0, valid0}, 32'd1);
      step();
    end
    check("abc_done_valid", {31'd0, valid0}, 32'd0);
    check("abc_done_busy", {31'd0, busy0}, 32'd0);
    check("abc_done_last", {31'd0, last0}, 32'd0);
    // stalls: ready pattern 1,0,0,1,...
    out_ready = 1'b0;
    start(abc_w);
    xfers = 0;
    foreach (vecs[k]) begin
      out_ready = vecs[k].rdy;
      check($sformatf("stall_word%0d", k), word0, abc_w[vecs[k].idx]);
      check($sformatf("stall_idx%0d", k), {29'd0, idx0}, vecs[k].idx);
      check($sformatf("stall_last%0d", k), {31'd0, last0}, {31'd0, vecs[k].idx == 7});
      if (vecs[k].rdy && valid0) xfers++;
      step();
    end
    out_ready = 1'b1;
    check("stall_xfers", xfers, 8);
    check("stall_done_valid", {31'd0, valid0}, 32'd0);
    // second digest at word 3, third dropped while both slots full
    exp16[0] = abc_w;
    exp16[1] = d2_w;
    start(abc_w);
    for (int c = 0; c < 16; c++) begin
      if (c == 2) begin
        hash_data = pack(d2_w);
        output_valid = 1'b1;
      end else if (c == 4) begin
        hash_data = pack(d3_w);
        output_valid = 1'b1;
      end else output_valid = 1'b0;
      check($sformatf("ovf_word%0d", c), word0, exp16[c/8][c%8]);
      check($sformatf("ovf_valid%0d", c), {31'd0, valid0}, 32'd1);
      if (c == 6) check("ovf_set", {31'd0, ovf0}, 32'd1);
      step();
    end
    check("ovf_d3_absent", {31'd0, valid0}, 32'd0);
    check("ovf_sticky", {31'd0, ovf0}, 32'd1);
    check("ovf_busy", {31'd0, busy0}, 32'd0);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    check("ovf_cleared", {31'd0, ovf0}, 32'd0);
    // new digest arriving with the final transfer
    start(abc_w);
    for (int c = 0; c < 16; c++) begin
      output_valid = c == 7;
      if (c == 7) hash_data = pack(d2_w);
      check($sformatf("b2b_word%0d", c), word0, exp16[c/8][c%8]);
      check($sformatf("b2b_idx%0d", c), {29'd0, idx0}, c % 8);
      check($sformatf("b2b_valid%0d", c), {31'd0, valid0}, 32'd1);
      step();
    end
    output_valid = 1'b0;
    check("b2b_done_valid", {31'd0, valid0}, 32'd0);
    // reset mid-digest
    start(abc_w);
    for (int c = 0; c < 4; c++) step();
    check("rst_pre_idx", {29'd0, idx0}, 32'd4);
    rst = 1'b0;
    #1;
    check("rst_valid", {31'd0, valid0}, 32'd0);
    check("rst_word", word0, 32'd0);
    check("rst_idx", {29'd0, idx0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_last", {31'd0, last0}, 32'd0);
    step();
    rst = 1'b1;
    step();
    check("rst_after_valid", {31'd0, valid0}, 32'd0);
    start(d3_w);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rst_new_w%0d", i), word0, d3_w[i]);
      check($sformatf("rst_new_idx%0d", i), {29'd0, idx0}, i);
      step();
    end
    check("rst_new_done", {31'd0, valid0}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
